tick_period_meter: RTL and testbench

//  Measures spacing between one-cycle tick pulses, inverse of the clock divider: a tick every N+1 cycles reports N.

---
 rtl/tick_period_meter_if.sv | 22 ++
 rtl/tick_period_meter.sv | 151 +++++++++++++++
 tb/tb_tick_period_meter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_period_meter_if.sv
// Tick/result bus of tick_period_meter: tick stream in, single-entry valid/ready result out.
interface tick_period_meter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             tick_in;
  logic [WIDTH-1:0] out_period;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             timeout;
  logic             locked;

  modport master (
    output tick_in, out_ready,
    input  out_period, out_valid, overrun, timeout, locked
  );

  modport slave (
    input  tick_in, out_ready,
    output out_period, out_valid, overrun, timeout, locked
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures cycles between tick events (a tick every N+1 cycles reports N) through a valid/ready register.
// Optional period-lock detector enabled by defining TICK_PERIOD_METER_LOCK_EN.
module tick_period_meter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_period_meter_if.slave   io_meter
);

  if (SYNC_STAGES > 3 || LOCK_COUNT < 2) begin : g_param_check
    $error("tick_period_meter: SYNC_STAGES must be 0..3 and LOCK_COUNT >= 2");
  end

  typedef enum logic {S_IDLE, S_MEAS} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_overrun;
  logic             r_timeout;
  logic             w_ev;
  logic             w_cnt_max;
  logic             w_capture;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_timeout_c;

  // Optional synchronizer; the last stage is the event strobe.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_ev = io_meter.tick_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= io_meter.tick_in;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
    end
    assign w_ev = r_sync[SYNC_STAGES-1];
  end

  assign w_cnt_max = &r_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ev) w_state_nxt = S_MEAS;
      S_MEAS:  if (!w_ev && w_cnt_max) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_timeout_c = 1'b0;
    case (r_state)
      S_IDLE: w_cnt_clr = w_ev;
      S_MEAS: begin
        if (w_ev) begin
          w_capture = 1'b1;
          w_cnt_clr = 1'b1;
        end else if (w_cnt_max) begin
          w_timeout_c = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  // Counter, status pulses and single-entry result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_count <= '0;
      else if (w_cnt_inc) r_count <= r_count + WIDTH'(1);
      r_timeout <= w_timeout_c;
      r_overrun <= w_capture && r_valid && !io_meter.out_ready;
      if (w_capture && (!r_valid || io_meter.out_ready)) begin
        r_period <= r_count;
        r_valid  <= 1'b1;
      end else if (r_valid && io_meter.out_ready && !w_capture) begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign io_meter.out_period = r_period;
  assign io_meter.out_valid  = r_valid;
  assign io_meter.overrun    = r_overrun;
  assign io_meter.timeout    = r_timeout;

`ifdef TICK_PERIOD_METER_LOCK_EN
  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0] r_ref;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic [RUN_W-1:0] w_run_nxt;

  // Run length of identical captures, saturating at LOCK_COUNT; dropped captures count too.
  always_comb begin
    w_run_nxt = RUN_W'(1);
    if (r_count == r_ref) begin
      w_run_nxt = (r_run == RUN_W'(LOCK_COUNT)) ? r_run : r_run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref    <= '0;
      r_run    <= '0;
      r_locked <= 1'b0;
    end else if (w_capture) begin
      r_ref    <= r_count;
      r_run    <= w_run_nxt;
      r_locked <= (w_run_nxt == RUN_W'(LOCK_COUNT));
    end else if (w_timeout_c) begin
      r_locked <= 1'b0;
    end
  end

  assign io_meter.locked = r_locked;
`else
  assign io_meter.locked = 1'b0;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomized scoreboard bench for tick_period_meter against a timestamp-based reference model.
module tb_tick_period_meter;
  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned LC = 4;
  localparam int          PMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tick_period_meter_if #(.WIDTH(W)) io ();

  tick_period_meter #(.WIDTH(W), .SYNC_STAGES(S), .LOCK_COUNT(LC)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_meter (io)
  );

  int n_vec = 0;
  int n_err = 0;

  int unsigned exp_res[$];
  int          exp_ovr[$];
  int          exp_to[$];
  bit          exp_lock[int];

  // Reference model: event timestamps give periods directly.
  int p_m = 0;
  bit th[$];
  bit m_act, m_val;
  int m_last;
`ifdef TICK_PERIOD_METER_LOCK_EN
  int m_ref, m_run;
`endif
  bit m_lock;

  always @(posedge clk) begin
    bit ev, cap, to;
    int per;
    p_m++;
    if (rst) begin
      th.delete();
      repeat (S) th.push_back(1'b0);
      m_act = 0; m_val = 0; m_last = 0; m_lock = 0;
`ifdef TICK_PERIOD_METER_LOCK_EN
      m_ref = 0; m_run = 0;
`endif
      exp_res.delete();
    end else begin
      th.push_back(io.tick_in);
      ev = th.pop_front();
      cap = 0; to = 0; per = 0;
      if (ev) begin
        if (m_act) begin
          cap = 1;
          per = p_m - m_last - 1;
        end
        m_act  = 1;
        m_last = p_m;
      end else if (m_act && (p_m - m_last - 1) == PMAX) begin
        to    = 1;
        m_act = 0;
      end
      if (cap) begin
        if (!m_val || io.out_ready) begin
          exp_res.push_back(per);
          m_val = 1;
        end else begin
          exp_ovr.push_back(p_m);
        end
`ifdef TICK_PERIOD_METER_LOCK_EN
        if (per == m_ref) m_run = (m_run < int'(LC)) ? m_run + 1 : m_run;
        else begin
          m_ref = per;
          m_run = 1;
        end
        m_lock = (m_run == int'(LC));
`endif
      end else if (m_val && io.out_ready) begin
        m_val = 0;
      end
      if (to) begin
        exp_to.push_back(p_m);
        m_lock = 0;
      end
    end
    exp_lock[p_m] = m_lock;
  end

  // Monitor: samples DUT outputs on the falling edge and pops the scoreboard.
  int c_m = 0;
  bit prev_rst = 1'b1;

  always @(negedge clk) begin
    bit e_now;
    c_m++;
    if (prev_rst) begin
      n_vec++;
      if ({io.out_valid, io.overrun, io.timeout, io.locked} !== 4'b0 || io.out_period !== '0) begin
        n_err++;
        $display("FAIL reset_state @%0d: got v=%0b o=%0b t=%0b l=%0b p=%0d, want all 0",
                 c_m, io.out_valid, io.overrun, io.timeout, io.locked, io.out_period);
      end
    end else begin
      n_vec++;
      if (io.out_valid !== (exp_res.size() != 0)) begin
        n_err++;
        $display("FAIL out_valid @%0d: got %0b, want %0b", c_m, io.out_valid, exp_res.size() != 0);
      end
      if (io.out_valid === 1'b1 && exp_res.size() != 0) begin
        n_vec++;
        if (io.out_period !== W'(exp_res[0])) begin
          n_err++;
          $display("FAIL out_period @%0d: got %0d, want %0d", c_m, io.out_period, exp_res[0]);
        end
        if (io.out_ready && !rst) void'(exp_res.pop_front());
      end
      e_now = (exp_ovr.size() != 0 && exp_ovr[0] == c_m);
      n_vec++;
      if (io.overrun !== e_now) begin
        n_err++;
        $display("FAIL overrun @%0d: got %0b, want %0b", c_m, io.overrun, e_now);
      end
      if (e_now) void'(exp_ovr.pop_front());
      e_now = (exp_to.size() != 0 && exp_to[0] == c_m);
      n_vec++;
      if (io.timeout !== e_now) begin
        n_err++;
        $display("FAIL timeout @%0d: got %0b, want %0b", c_m, io.timeout, e_now);
      end
      if (e_now) void'(exp_to.pop_front());
      n_vec++;
      if (io.locked !== exp_lock[c_m]) begin
        n_err++;
        $display("FAIL locked @%0d: got %0b, want %0b", c_m, io.locked, exp_lock[c_m]);
      end
    end
    prev_rst = rst;
  end

  task automatic step(input bit t, input bit r, input bit rs);
    @(posedge clk);
    #1;
    io.tick_in   = t;
    io.out_ready = r;
    rst          = rs;
  endtask

  task automatic pulse_gap(input int gap, input bit r);
    step(1'b1, r, 1'b0);
    for (int j = 0; j < gap; j++) step(1'b0, r, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    io.tick_in = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Pulse every 10 clocks -> period 9.
    for (int k = 0; k < 6; k++) pulse_gap(9, 1'b1);
    // Held high -> period 0 every cycle.
    repeat (20) step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    // Back-pressure with pulses every 6 clocks -> overrun.
    for (int k = 0; k < 4; k++) pulse_gap(5, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    // Maximum period, then timeout, then recovery.
    pulse_gap(255, 1'b1);
    pulse_gap(300, 1'b1);
    pulse_gap(7, 1'b1);
    pulse_gap(7, 1'b1);
    // Lock pattern: periods 5,5,5,5 then 6.
    for (int k = 0; k < 5; k++) pulse_gap(5, 1'b1);
    pulse_gap(6, 1'b1);
    pulse_gap(6, 1'b1);
    // Reset mid-measure with a result pending.
    pulse_gap(4, 1'b0);
    pulse_gap(3, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    pulse_gap(5, 1'b1);
    pulse_gap(5, 1'b1);

    // Randomized gaps, back-pressure and occasional resets.
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) step(1'b0, 1'b1, 1'b1);
      step(1'b1, $urandom_range(0, 3) != 0, 1'b0);
      for (int j = 0; j < gap; j++) step(1'b0, $urandom_range(0, 3) != 0, 1'b0);
    end

    repeat (10) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (exp_res.size() != 0) begin
      n_err++;
      $display("FAIL drain_results: got %0d pending, want 0", exp_res.size());
    end
    step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (exp_ovr.size() != 0 || exp_to.size() != 0) begin
      n_err++;
      $display("FAIL drain_pulses: got ovr=%0d to=%0d pending, want 0", exp_ovr.size(), exp_to.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
